// File: rtl/vec_lane_serializer.sv
// Vector-to-lane serializer: takes one NUM_LANES x WIDTH vector per input handshake
// and emits it lane 0 first, one lane per output beat, flagging the final lane.
module vec_lane_serializer #(
    parameter int NUM_LANES = 3,
    parameter int WIDTH     = 3,
    localparam int IDXW     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_LANES*WIDTH-1:0] in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [IDXW-1:0]            out_idx,
    output logic                       out_last
);

    // Valid/ready: a transfer happens on any rising edge where valid && ready; the
    // producer holds valid and data stable until that edge, and ready never waits on valid.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_LANES - 1);

    logic [0:0]       state_q;
    logic [IDXW-1:0]  cnt_q;
    logic [WIDTH-1:0] lane_q [NUM_LANES];
    logic             busy;
    logic             beat_fire;
    logic             in_fire;

    assign busy      = (state_q == ST_SEND);
    assign out_valid = busy;
    assign out_idx   = cnt_q;
    assign out_data  = lane_q[cnt_q];
    assign out_last  = busy && (cnt_q == LAST_IDX);

    // Accepting on the last beat lets the next vector follow with no bubble.
    assign in_ready  = !rst && (!busy || (out_ready && out_last));
    assign beat_fire = out_valid && out_ready;
    assign in_fire   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                lane_q[i] <= '0;
            end
        end else if (in_fire) begin
            state_q <= ST_SEND;
            cnt_q   <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                lane_q[i] <= in_data[i*WIDTH +: WIDTH];
            end
        end else if (beat_fire) begin
            if (out_last) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + IDXW'(1);
            end
        end
    end

endmodule

// File: tb/tb_vec_lane_serializer.sv
// Bench for vec_lane_serializer: vector table, hand-written corner sequences,
// a single-lane instance, and random traffic against a beat-queue reference model.
module tb_vec_lane_serializer;

    localparam int NL = 3;
    localparam int W  = 3;
    localparam int IW = 2;
    localparam int QW = 1 + IW + W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [NL*W-1:0] in_data = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [W-1:0]    out_data;
    logic [IW-1:0]   out_idx;
    logic            out_last;

    logic       in_valid1 = 1'b0;
    logic       in_ready1;
    logic [7:0] in_data1 = '0;
    logic       out_valid1;
    logic       out_ready1 = 1'b1;
    logic [7:0] out_data1;
    logic [0:0] out_idx1;
    logic       out_last1;

    vec_lane_serializer #(.NUM_LANES(NL), .WIDTH(W)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last)
    );

    vec_lane_serializer #(.NUM_LANES(1), .WIDTH(8)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .out_idx(out_idx1), .out_last(out_last1)
    );

    typedef struct {
        logic [NL*W-1:0] data;
        logic [W-1:0]    exp_lane [NL];
    } vec_t;

    vec_t tbl [4];
    int total = 0;
    int bad   = 0;
    logic [QW-1:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Offer one vector from idle and follow all of its beats with out_ready held high.
    task automatic run_vector(input int t);
        in_data   = tbl[t].data;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check("tbl_in_ready", in_ready, 1);
        cyc();
        in_valid = 1'b0;
        for (int i = 0; i < NL; i++) begin
            check("tbl_valid", out_valid, 1);
            check("tbl_data", out_data, tbl[t].exp_lane[i]);
            check("tbl_idx", out_idx, i);
            check("tbl_last", out_last, (i == NL - 1) ? 1 : 0);
            cyc();
        end
        check("tbl_done_valid", out_valid, 0);
    endtask

    task automatic run_random(input int cycles);
        logic      hold;
        logic      exp_v;
        logic      exp_ir;
        logic      acc;
        logic      pop;
        logic [QW-1:0] item;
        hold = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            if (!hold) begin
                in_valid = ($urandom_range(0, 2) != 0);
                in_data  = (NL*W)'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_v  = (exp_q.size() > 0);
            exp_ir = (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready);
            check("rnd_valid", out_valid, exp_v);
            check("rnd_in_ready", in_ready, exp_ir);
            if (exp_v) begin
                item = exp_q[0];
                check("rnd_data", out_data, item[W-1:0]);
                check("rnd_idx", out_idx, item[W +: IW]);
                check("rnd_last", out_last, item[QW-1]);
            end
            acc = in_valid && exp_ir;
            pop = exp_v && out_ready;
            @(posedge clk);
            if (pop) void'(exp_q.pop_front());
            if (acc) begin
                for (int i = 0; i < NL; i++) begin
                    exp_q.push_back({(i == NL - 1), IW'(i), in_data[i*W +: W]});
                end
            end
            hold = in_valid && !acc;
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (NL + 1) cyc();
        check("rnd_drained", out_valid, 0);
    endtask

    initial begin
        tbl[0].data = 9'b101_010_111; tbl[0].exp_lane = '{3'd7, 3'd2, 3'd5};
        tbl[1].data = 9'b000_000_000; tbl[1].exp_lane = '{3'd0, 3'd0, 3'd0};
        tbl[2].data = 9'b111_111_111; tbl[2].exp_lane = '{3'd7, 3'd7, 3'd7};
        tbl[3].data = 9'b001_110_011; tbl[3].exp_lane = '{3'd3, 3'd6, 3'd1};

        // Reset held for two edges, then released.
        rst = 1'b1;
        cyc();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        cyc();
        rst = 1'b0;
        #1;
        check("rel_in_ready", in_ready, 1);
        check("rel_out_valid", out_valid, 0);
        check("rel_out_data", out_data, 0);
        check("rel_out_idx", out_idx, 0);
        check("rel_out_last", out_last, 0);
        check("rel1_out_valid", out_valid1, 0);
        check("rel1_in_ready", in_ready1, 1);

        for (int t = 0; t < 4; t++) run_vector(t);

        // Back-to-back: vector 0 then vector 3 with no bubble.
        in_data  = tbl[0].data;
        in_valid = 1'b1;
        cyc();
        in_data = tbl[3].data;
        for (int b = 0; b < 2 * NL; b++) begin
            #1;
            check("b2b_valid", out_valid, 1);
            check("b2b_data", out_data, (b < NL) ? tbl[0].exp_lane[b] : tbl[3].exp_lane[b - NL]);
            check("b2b_idx", out_idx, b % NL);
            check("b2b_in_ready", in_ready, (b % NL == NL - 1) ? 1 : 0);
            cyc();
            if (b == NL - 1) in_valid = 1'b0;
        end
        check("b2b_end_valid", out_valid, 0);

        // Backpressure during lane 1.
        in_data  = tbl[0].data;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        check("bp_lane0", out_data, 7);
        cyc();
        out_ready = 1'b0;
        for (int s = 0; s < 4; s++) begin
            #1;
            check("bp_valid", out_valid, 1);
            check("bp_data", out_data, 2);
            check("bp_idx", out_idx, 1);
            check("bp_last", out_last, 0);
            check("bp_in_ready", in_ready, 0);
            cyc();
        end
        out_ready = 1'b1;
        #1;
        check("bp_resume_data", out_data, 2);
        check("bp_resume_idx", out_idx, 1);
        cyc();
        check("bp_lane2_data", out_data, 5);
        check("bp_lane2_last", out_last, 1);
        cyc();
        check("bp_end_valid", out_valid, 0);

        // Reset asserted while lane 1 is presented.
        in_data  = tbl[0].data;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        cyc();
        check("mr_idx_before", out_idx, 1);
        rst = 1'b1;
        #1;
        check("mr_in_ready_rst", in_ready, 0);
        cyc();
        check("mr_valid", out_valid, 0);
        rst = 1'b0;
        in_data  = tbl[3].data;
        in_valid = 1'b1;
        #1;
        check("mr_in_ready", in_ready, 1);
        cyc();
        in_valid = 1'b0;
        check("mr_new_valid", out_valid, 1);
        check("mr_new_idx", out_idx, 0);
        check("mr_new_data", out_data, 3);
        repeat (NL) cyc();
        check("mr_end_valid", out_valid, 0);

        // Single-lane instance.
        in_data1  = 8'hA5;
        in_valid1 = 1'b1;
        #1;
        check("n1_in_ready", in_ready1, 1);
        cyc();
        in_data1 = 8'h3C;
        #1;
        check("n1_valid", out_valid1, 1);
        check("n1_data", out_data1, 8'hA5);
        check("n1_idx", out_idx1, 0);
        check("n1_last", out_last1, 1);
        check("n1_b2b_ready", in_ready1, 1);
        cyc();
        in_valid1 = 1'b0;
        check("n1_data2", out_data1, 8'h3C);
        check("n1_last2", out_last1, 1);
        cyc();
        check("n1_end_valid", out_valid1, 0);

        run_random(3000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
